// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-port word-addressed data memory (port 0 = CPU, port 1 = debug).
// Round-robin on contention, registered write strobe, registered read data and one-cycle acks.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, ACK} state_t;

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_reg, state_next;
    logic [1:0]        req;
    logic [1:0]        we_in;
    logic [ADDR_W-1:0] addr_in [2];
    logic [DATA_W-1:0] wdata_in [2];
    logic              grant_valid, grant_port, grant_oor;
    logic              grant_take, rd_capture, ack_fire, wr_next;
    logic              port_reg, we_reg, err_reg, last_grant_reg, mem_wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        ack_vec, err_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    assign req         = {dbg_req, cpu_req};
    assign we_in       = {dbg_we, cpu_we};
    assign addr_in[0]  = cpu_addr;
    assign addr_in[1]  = dbg_addr;
    assign wdata_in[0] = cpu_wdata;
    assign wdata_in[1] = dbg_wdata;

    // On contention the port that did not win last time is served.
    always_comb begin
        grant_valid = |req;
        grant_port  = (req == 2'b11) ? ~last_grant_reg : req[1];
        grant_oor   = {1'b0, addr_in[grant_port]} >= ADDR_LIMIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (grant_valid) begin
                if (grant_oor)               state_next = ACK;
                else if (we_in[grant_port])  state_next = WS;
                else                         state_next = RD;
            end
            RD:      state_next = ACK;
            WS:      state_next = WP;
            WP:      state_next = WH;
            WH:      state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_take = (state_reg == IDLE) && grant_valid;
        rd_capture = (state_reg == RD);
        ack_fire   = (state_reg == ACK);
        wr_next    = (state_next == WP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_reg       <= 1'b0;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            mem_wr_reg     <= 1'b0;
        end else begin
            if (grant_take) begin
                port_reg       <= grant_port;
                last_grant_reg <= grant_port;
                we_reg         <= we_in[grant_port];
                err_reg        <= grant_oor;
                addr_reg       <= addr_in[grant_port];
                wdata_reg      <= wdata_in[grant_port];
            end
            // Strobe comes straight from a flop so the memory sees one clean edge.
            mem_wr_reg <= wr_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              ack_reg, err_out_reg;
        logic [DATA_W-1:0] rdata_reg;
        logic              is_mine;

        assign is_mine = (port_reg == 1'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ack_reg     <= 1'b0;
                err_out_reg <= 1'b0;
                rdata_reg   <= '0;
            end else begin
                ack_reg     <= ack_fire && is_mine;
                err_out_reg <= ack_fire && is_mine && err_reg;
                if (rd_capture && is_mine) rdata_reg <= mem_rdata;
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign err_vec[gi]   = err_out_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign cpu_ack   = ack_vec[0];
    assign cpu_err   = err_vec[0];
    assign cpu_rdata = rdata_vec[0];
    assign dbg_ack   = ack_vec[1];
    assign dbg_err   = err_vec[1];
    assign dbg_rdata = rdata_vec[1];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wr    = mem_wr_reg;

    // we_reg is kept for completeness of the latched request; fold it in harmlessly.
    logic unused_we;
    assign unused_we = we_reg;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level model of memory and ports.
module tb_dmem_port_arbiter;
    localparam int AW = 32, DW = 32, DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_wr;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    // Memory that the arbiter drives: writes on the rising edge of mem_wr.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge mem_wr) if (mem_addr < 32'(DEPTH)) mem[mem_addr[9:0]] = mem_wdata;
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[9:0]] : '0;

    // Reference model: expected memory contents and each port's last read value.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rdata [2];

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one transaction on an idle arbiter; observe until the port's ack.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rdata, output int wr_cyc, output int bad,
                          output int other);
        lat = -1; err = 1'b0; rdata = '0; wr_cyc = 0; bad = 0; other = 0;
        if (port) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        @(posedge clk); #1;
        if (mem_addr !== addr) bad++;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (mem_wr) wr_cyc++;
            if (mem_addr !== addr || (we && mem_wdata !== wdata)) bad++;
            if (port ? cpu_ack : dbg_ack) other++;
            if (port ? dbg_ack : cpu_ack) begin
                lat   = c;
                err   = port ? dbg_err : cpu_err;
                rdata = port ? dbg_rdata : cpu_rdata;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    int            ack_port [8];
    logic [31:0]   ack_data [8];

    // Both ports request reads continuously; record which port each ack goes to.
    task automatic run_contention(input logic [31:0] ac, input logic [31:0] ad,
                                  input int n, output int got);
        cpu_we = 1'b0; cpu_addr = ac; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = ad; dbg_req = 1'b1;
        got = 0;
        for (int c = 0; c < 20 * n && got < n; c++) begin
            @(posedge clk); #1;
            if (cpu_ack && dbg_ack) begin
                ack_port[got] = 2; ack_data[got] = '0; got++;
            end else if (cpu_ack) begin
                ack_port[got] = 0; ack_data[got] = cpu_rdata; got++;
            end else if (dbg_ack) begin
                ack_port[got] = 1; ack_data[got] = dbg_rdata; got++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat, wr_cyc, bad, other, got, lat1;
        logic        err, done, seen;
        logic [31:0] rdata, a, d, exp_rd;
        bit          p, w, e;

        vecs[0] = '{0, 1, 32'd5,          32'hDEADBEEF, 0, 32'h0,        4, 1};
        vecs[1] = '{0, 0, 32'd5,          32'h0,        0, 32'hDEADBEEF, 2, 0};
        vecs[2] = '{1, 1, 32'd1024,       32'h11111111, 1, 32'h0,        1, 0};
        vecs[3] = '{1, 0, 32'd5,          32'h0,        0, 32'hDEADBEEF, 2, 0};
        vecs[4] = '{1, 1, 32'd1023,       32'h12345678, 0, 32'hDEADBEEF, 4, 1};
        vecs[5] = '{0, 0, 32'd1023,       32'h0,        0, 32'h12345678, 2, 0};
        vecs[6] = '{0, 0, 32'hFFFFFFFF,   32'h0,        1, 32'h12345678, 1, 0};
        vecs[7] = '{1, 0, 32'd1024,       32'h0,        1, 32'hDEADBEEF, 1, 0};
        vecs[8] = '{0, 0, 32'd0,          32'h0,        0, 32'h0,        2, 0};

        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[1] = 32'h11110001; ref_mem[1] = 32'h11110001;
        mem[2] = 32'h22220002; ref_mem[2] = 32'h22220002;
        ref_rdata[0] = '0; ref_rdata[1] = '0;

        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_wr",    32'(mem_wr), 0);
        check("rst_cpu_ack",   32'(cpu_ack), 0);
        check("rst_dbg_ack",   32'(dbg_ack), 0);
        check("rst_cpu_err",   32'(cpu_err), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   lat, err, rdata, wr_cyc, bad, other);
            $display("vec %0d port=%0d we=%0d addr=0x%0h lat=%0d err=%0d rdata=0x%0h wr=%0d",
                     i, vecs[i].port, vecs[i].we, vecs[i].addr, lat, err, rdata, wr_cyc);
            check($sformatf("v%0d_lat", i),   lat, vecs[i].exp_lat);
            check($sformatf("v%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_wr", i),    wr_cyc, vecs[i].exp_wr);
            check($sformatf("v%0d_bus", i),   bad, 0);
            check($sformatf("v%0d_other", i), other, 0);
            if (vecs[i].we && !vecs[i].exp_err) ref_mem[vecs[i].addr[9:0]] = vecs[i].wdata;
            ref_rdata[vecs[i].port] = vecs[i].exp_rdata;
        end
        check("mem5_contents", mem[5], 32'hDEADBEEF);

        // Round robin: both requesting from reset, CPU first, strict alternation
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd1;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'd2;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_contention(32'd1, 32'd2, 4, got);
        $display("contention acks=%0d order=%0d %0d %0d %0d", got,
                 ack_port[0], ack_port[1], ack_port[2], ack_port[3]);
        check("rr_count", got, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_order%0d", i), ack_port[i], i % 2);
            check($sformatf("rr_data%0d", i), ack_data[i], (i % 2) ? ref_mem[2] : ref_mem[1]);
        end

        // Reset while the write pulse is high
        cpu_we = 1; cpu_addr = 32'd7; cpu_wdata = 32'hA5A50007; cpu_req = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (mem_wr) seen = 1'b1;
        end
        check("wp_reached", 32'(seen), 1);
        #1 reset = 1'b1;
        #1;
        check("wp_rst_mem_wr",  32'(mem_wr), 0);
        check("wp_rst_cpu_ack", 32'(cpu_ack), 0);
        check("wp_rst_mem_addr", mem_addr, 0);
        cpu_req = 0; cpu_we = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("wp_write_landed", mem[7], 32'hA5A50007);
        ref_mem[7] = 32'hA5A50007;
        run_contention(32'd7, 32'd2, 2, got);
        $display("post-reset contention acks=%0d first=%0d data=0x%0h", got, ack_port[0], ack_data[0]);
        check("wp_count", got, 2);
        check("wp_first_cpu", ack_port[0], 0);
        check("wp_reread", ack_data[0], ref_mem[7]);
        check("wp_second_dbg", ack_port[1], 1);
        ref_rdata[0] = ref_mem[7];
        ref_rdata[1] = ref_mem[2];

        // Debug changes its address while the CPU write is in flight
        cpu_we = 1; cpu_addr = 32'd9; cpu_wdata = 32'hC0DE0009; cpu_req = 1;
        @(posedge clk); #1;
        dbg_we = 1; dbg_addr = 32'd100; dbg_wdata = 32'hBBBB0000; dbg_req = 1;
        bad = 0; done = 0; lat1 = -1;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 2) dbg_addr = 32'd200;
            if (mem_addr !== 32'd9) bad++;
            if (dbg_ack) bad++;
            if (cpu_ack) begin done = 1; lat1 = c; end
        end
        cpu_req = 0;
        check("t6_cpu_lat", lat1, 4);
        check("t6_addr_stable", bad, 0);
        done = 0; lat = -1;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(posedge clk); #1;
            if (dbg_ack) begin done = 1; lat = c; end
        end
        dbg_req = 0;
        $display("t6 cpu_lat=%0d dbg_wait=%0d mem_addr=0x%0h", lat1, lat, mem_addr);
        check("t6_dbg_wait", lat, 5);
        check("t6_dbg_addr", mem_addr, 32'd200);
        check("t6_mem200", mem[200], 32'hBBBB0000);
        check("t6_mem100", mem[100], ref_mem[100]);
        check("t6_mem9", mem[9], 32'hC0DE0009);
        ref_mem[9] = 32'hC0DE0009;
        ref_mem[200] = 32'hBBBB0000;

        // Randomized single transactions against the model
        for (int i = 0; i < 30; i++) begin
            int r;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 6)      a = $urandom_range(0, 15);
            else if (r < 8) a = $urandom_range(1020, 1027);
            else            a = $urandom;
            d = $urandom;
            e = (a >= 32'(DEPTH));
            exp_rd = (!w && !e) ? ref_mem[a[9:0]] : ref_rdata[p];
            do_txn(p, w, a, d, lat, err, rdata, wr_cyc, bad, other);
            $display("rnd %0d port=%0d we=%0d addr=0x%0h wdata=0x%0h lat=%0d err=%0d rdata=0x%0h",
                     i, p, w, a, d, lat, err, rdata);
            check($sformatf("r%0d_lat", i),   lat, e ? 1 : (w ? 4 : 2));
            check($sformatf("r%0d_err", i),   32'(err), 32'(e));
            check($sformatf("r%0d_rdata", i), rdata, exp_rd);
            check($sformatf("r%0d_wr", i),    wr_cyc, (w && !e) ? 1 : 0);
            check($sformatf("r%0d_bus", i),   bad, 0);
            check($sformatf("r%0d_other", i), other, 0);
            ref_rdata[p] = exp_rd;
            if (w && !e) ref_mem[a[9:0]] = d;
        end
        for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
